// File: rtl/seg7_frame_decoder.sv
// Serial 8-bit frame receiver that maps 7-segment codes back to {carry, digit},
// flags illegal codes and truncated frames, and keeps a saturating error count.
module seg7_frame_decoder (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam int unsigned FRAME_W = 8;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned DIG_W   = 3;
    localparam int unsigned VAL_W   = 4;
    localparam int unsigned ERR_W   = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    logic w_clk;
    logic w_rst;
    logic w_sdata;
    logic w_sframe;
    logic w_show_errcnt;
    logic w_unused_rsvd;

    assign w_clk         = io_in[0];
    assign w_rst         = io_in[1];
    assign w_sdata       = io_in[2];
    assign w_sframe      = io_in[3];
    assign w_show_errcnt = io_in[4];
    assign w_unused_rsvd = ^io_in[7:5];

    state_t             r_state;
    logic [CNT_W-1:0]   r_bitcnt;
    logic [SEG_W-1:0]   r_shift;
    logic [VAL_W-1:0]   r_value;
    logic [ERR_W-1:0]   r_errcnt;
    logic               r_valid;
    logic               r_seg_err;
    logic               r_frame_err;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_bitcnt_nxt;
    logic [SEG_W-1:0]   w_shift_nxt;
    logic [VAL_W-1:0]   w_value_nxt;
    logic [ERR_W-1:0]   w_errcnt_nxt;
    logic               w_valid_nxt;
    logic               w_seg_err_nxt;
    logic               w_frame_err_nxt;
    logic               w_err_event;

    logic               w_legal;
    logic [DIG_W-1:0]   w_digit;

    // Segment code lookup on the seven bits already shifted in (s6..s0)
    always_comb begin
        w_legal = 1'b1;
        w_digit = DIG_W'(0);
        case (r_shift)
            7'h3F:   w_digit = DIG_W'(0);
            7'h30:   w_digit = DIG_W'(1);
            7'h5B:   w_digit = DIG_W'(2);
            7'h4F:   w_digit = DIG_W'(3);
            7'h66:   w_digit = DIG_W'(4);
            7'h6D:   w_digit = DIG_W'(5);
            7'h7D:   w_digit = DIG_W'(6);
            7'h07:   w_digit = DIG_W'(7);
            default: w_legal = 1'b0;
        endcase
    end

    // Next-state, datapath and pulse generation
    always_comb begin
        w_state_nxt     = r_state;
        w_bitcnt_nxt    = r_bitcnt;
        w_shift_nxt     = r_shift;
        w_value_nxt     = r_value;
        w_errcnt_nxt    = r_errcnt;
        w_valid_nxt     = 1'b0;
        w_seg_err_nxt   = 1'b0;
        w_frame_err_nxt = 1'b0;
        w_err_event     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_sframe) begin
                    w_shift_nxt  = {w_sdata, r_shift[SEG_W-1:1]};
                    w_bitcnt_nxt = CNT_W'(1);
                    w_state_nxt  = ST_RECV;
                end
            end
            ST_RECV: begin
                if (w_sframe) begin
                    if (r_bitcnt == CNT_W'(FRAME_W - 1)) begin
                        // Incoming bit is the carry; segment bits are all in r_shift
                        w_bitcnt_nxt = CNT_W'(0);
                        w_shift_nxt  = SEG_W'(0);
                        w_state_nxt  = ST_IDLE;
                        if (w_legal) begin
                            w_value_nxt = {w_sdata, w_digit};
                            w_valid_nxt = 1'b1;
                        end else begin
                            w_seg_err_nxt = 1'b1;
                            w_err_event   = 1'b1;
                        end
                    end else begin
                        w_shift_nxt  = {w_sdata, r_shift[SEG_W-1:1]};
                        w_bitcnt_nxt = r_bitcnt + CNT_W'(1);
                    end
                end else begin
                    // sframe dropped mid-frame: discard partial data
                    w_frame_err_nxt = 1'b1;
                    w_err_event     = 1'b1;
                    w_bitcnt_nxt    = CNT_W'(0);
                    w_shift_nxt     = SEG_W'(0);
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_bitcnt_nxt = CNT_W'(0);
                w_shift_nxt  = SEG_W'(0);
                w_state_nxt  = ST_IDLE;
            end
        endcase

        if (w_err_event && (r_errcnt != {ERR_W{1'b1}})) begin
            w_errcnt_nxt = r_errcnt + ERR_W'(1);
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_state     <= ST_IDLE;
            r_bitcnt    <= CNT_W'(0);
            r_shift     <= SEG_W'(0);
            r_value     <= VAL_W'(0);
            r_errcnt    <= ERR_W'(0);
            r_valid     <= 1'b0;
            r_seg_err   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bitcnt    <= w_bitcnt_nxt;
            r_shift     <= w_shift_nxt;
            r_value     <= w_value_nxt;
            r_errcnt    <= w_errcnt_nxt;
            r_valid     <= w_valid_nxt;
            r_seg_err   <= w_seg_err_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    // Display mux is combinational so show_errcnt never touches state
    assign io_out = {(r_state == ST_RECV), r_frame_err, r_seg_err, r_valid,
                     (w_show_errcnt ? r_errcnt : r_value)};

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Self-checking bench for seg7_frame_decoder: directed scenarios plus random
// frames, compared every cycle against a queue-based reference model.
module tb_seg7_frame_decoder;

    logic       clk;
    logic       rst;
    logic       sdata;
    logic       sframe;
    logic       show;
    logic [2:0] rsv;
    logic [7:0] io_in;
    logic [7:0] io_out;

    assign io_in = {rsv, show, sframe, sdata, rst, clk};

    seg7_frame_decoder dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    bit         q[$];
    logic [3:0] m_value;
    logic [3:0] m_err;
    logic       m_valid;
    logic       m_seg;
    logic       m_ferr;
    logic [6:0] codes [8] = '{7'h3F, 7'h30, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic bump_err();
        if (m_err < 4'd15) m_err = m_err + 4'd1;
    endtask

    // Model of one rising edge using the currently driven inputs
    task automatic model_edge();
        logic [7:0] fb;
        bit         found;
        int         dig;
        m_valid = 1'b0;
        m_seg   = 1'b0;
        m_ferr  = 1'b0;
        if (rst) begin
            q.delete();
            m_value = 4'h0;
            m_err   = 4'h0;
        end else if (sframe) begin
            q.push_back(sdata);
            if (q.size() == 8) begin
                for (int i = 0; i < 8; i++) fb[i] = q[i];
                found = 0;
                dig   = 0;
                for (int i = 0; i < 8; i++) begin
                    if (codes[i] == fb[6:0]) begin
                        found = 1;
                        dig   = i;
                    end
                end
                if (found) begin
                    m_value = {fb[7], 3'(dig)};
                    m_valid = 1'b1;
                end else begin
                    m_seg = 1'b1;
                    bump_err();
                end
                q.delete();
            end
        end else if (q.size() != 0) begin
            m_ferr = 1'b1;
            bump_err();
            q.delete();
        end
    endtask

    function automatic logic [7:0] model_out();
        return {(q.size() != 0), m_ferr, m_seg, m_valid, (show ? m_err : m_value)};
    endfunction

    // Drive one cycle, advance the model, check at the falling edge
    task automatic step(input logic d, input logic f, input logic s, input logic r);
        rst    = r;
        sdata  = d;
        sframe = f;
        show   = s;
        rsv    = 3'($urandom);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("cycle", io_out, model_out());
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input logic s);
        for (int i = 0; i < n; i++) step(b[i], 1'b1, s, 1'b0);
    endtask

    task automatic send(input logic [7:0] b, input logic s);
        send_bits(b, 8, s);
    endtask

    initial begin
        int sel;
        int n;
        logic [7:0] b;
        int exp_cnt;

        rst = 1'b1; sdata = 1'b0; sframe = 1'b0; show = 1'b0; rsv = 3'b0;

        // Reset
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("reset", io_out, 8'h00);

        // Legal frame 0xDB -> value 0xA
        send(8'hDB, 1'b0);
        chk("db_valid", io_out, 8'h1A);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("db_hold", io_out, 8'h0A);

        // Illegal frame keeps value, bumps count
        send(8'h7F, 1'b0);
        chk("seg_err", io_out, 8'h2A);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("errcnt1", io_out, 8'h01);

        // Short frame then a legal one
        send_bits(8'h3F, 5, 1'b0);
        chk("busy5", io_out, 8'h8A);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("frame_err", io_out, 8'h4A);
        send(8'h3F, 1'b0);
        chk("after_short", io_out, 8'h10);

        // Back-to-back frames with sframe held high
        send(8'h30, 1'b0);
        chk("b2b_first", io_out, 8'h11);
        send(8'h87, 1'b0);
        chk("b2b_second", io_out, 8'h1F);

        // Reset mid-frame, then a clean frame
        send_bits(8'hCF, 4, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("mid_rst", io_out, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst", io_out, 8'h00);
        send(8'h4F, 1'b0);
        chk("after_rst", io_out, 8'h13);

        // Error count saturation
        step(1'b0, 1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 17; k++) begin
            send(8'h00, 1'b1);
            exp_cnt = (k > 15) ? 15 : k;
            chk("sat", io_out, 8'h20 | 8'(exp_cnt));
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("sat_value", io_out, 8'h00);

        // Randomized traffic
        for (int it = 0; it < 400; it++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 4) begin
                b = {1'($urandom), codes[$urandom_range(0, 7)]};
                send(b, 1'($urandom));
            end else if (sel <= 6) begin
                send(8'($urandom), 1'($urandom));
            end else if (sel == 7) begin
                n = $urandom_range(1, 7);
                send_bits(8'($urandom), n, 1'($urandom));
                step(1'($urandom), 1'b0, 1'($urandom), 1'b0);
            end else if (sel == 8) begin
                n = $urandom_range(1, 3);
                for (int j = 0; j < n; j++) step(1'($urandom), 1'b0, 1'($urandom), 1'b0);
            end else begin
                n = $urandom_range(0, 7);
                send_bits(8'($urandom), n, 1'($urandom));
                step(1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
